stream_comparator: RTL and testbench
====================================

STREAM_COMPARATOR -- requirements
Module: stream_comparator

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits, legal range 2..32.
REQ-002 Parameter SIGNED_MODE, default 1: 1 compares as two's complement, 0 compares as unsigned.
REQ-003 Parameter CNT_W, default 16: sample-counter width in bits.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  operand pair a/b is presented.
REQ-008 in_ready  output  1  block can accept a pair this cycle.
REQ-009 a  input  WIDTH  operand A.
REQ-010 b  input  WIDTH  operand B.
REQ-011 clr  input  1  synchronous clear of min/max/count tracking.
REQ-012 out_valid  output  1  result registers hold an unconsumed result.
REQ-013 out_ready  input  1  downstream consumes the result.
REQ-014 a_gt_b, a_eq_b, a_lt_b  output  1 each  registered compare flags, one-hot when out_valid=1.
REQ-015 max_a  output  WIDTH  largest A accepted since the last reset/clr.
REQ-016 min_a  output  WIDTH  smallest A accepted since the last reset/clr.
REQ-017 sample_cnt  output  CNT_W  pairs accepted since the last reset/clr.

Function
REQ-018 in_ready = !out_valid || out_ready (combinational; single-entry output register with pass-through on consume).
REQ-019 Accept occurs when in_valid && in_ready at a rising edge; no other event captures a/b.
REQ-020 On accept, the compare flags register the result of a vs b in the configured signedness; latency is 1 cycle, and out_valid=1 in the following cycle.
REQ-021 While out_valid=1 and out_ready=0, the flags, out_valid, max_a and min_a remain stable, and no new pair is accepted.
REQ-022 When out_valid=1 && out_ready=1 with no accept, out_valid drops to 0 on the next edge.
REQ-023 When a consume and an accept occur in the same cycle, out_valid stays 1 and the flags update to the new pair (back-to-back throughput of 1/cycle).
REQ-024 Tracking state is EMPTY (sample_cnt=0) or ACTIVE (sample_cnt>0).
REQ-025 An accept in EMPTY loads max_a=min_a=a and sets sample_cnt=1, moving to ACTIVE.
REQ-026 An accept in ACTIVE sets max_a=a if a>max_a and min_a=a if a<min_a (configured signedness; ties leave the value unchanged), and increments sample_cnt.
REQ-027 sample_cnt saturates at 2^CNT_W-1; min/max continue updating after saturation.
REQ-028 clr without an accept sets max_a=min_a=0 and sample_cnt=0 (EMPTY), and leaves out_valid and the flags untouched.
REQ-029 clr with a simultaneous accept behaves as an accept in EMPTY: min=max=a, sample_cnt=1, and the flags update normally.
REQ-030 All outputs are registered except in_ready.
REQ-031 a_eq_b is pure bitwise equality, independent of SIGNED_MODE.

Reset
REQ-032 rst_n=0 immediately forces out_valid=0, all flags=0, max_a=min_a=0 and sample_cnt=0, independent of clk.
REQ-033 While rst_n=0, in_ready=1 and no accept occurs; the first accept is possible on the first rising edge after rst_n deasserts.
REQ-034 Assertion of rst_n mid-transfer discards any pending result without producing a partial output.

Verification
REQ-035 WIDTH=4, SIGNED_MODE=1: a=4'hF, b=4'h1 accepted -> next cycle out_valid=1, a_lt_b=1, max_a=min_a=4'hF, sample_cnt=1.
REQ-036 WIDTH=4, SIGNED_MODE=0, same stimulus -> a_gt_b=1; then a=4'h7 -> max_a=4'hF, min_a=4'h7, sample_cnt=2.
REQ-037 Backpressure: out_ready=0 for 3 cycles after a result -> in_ready=0, outputs stable; then out_ready=1 with in_valid=1 -> new result the next cycle, no bubble.
REQ-038 Streaming signed a=-8,7,0,-8 (b=0), out_ready=1 -> flags lt,gt,eq,lt on consecutive cycles; final max_a=7, min_a=-8, sample_cnt=4.
REQ-039 clr alone in ACTIVE -> sample_cnt=0, min/max=0, and a pending result is held; clr together with accept of a=3 -> min=max=3, sample_cnt=1.
REQ-040 CNT_W=2: five accepts -> sample_cnt sticks at 3; assert rst_n=0 while out_valid=1 -> all outputs cleared without waiting for a clock edge.

Source files
------------

// File: rtl/stream_comparator.sv
// stream_comparator: registered a/b compare behind a one-entry valid/ready stage,
// with running min/max of A and a saturating sample count.
module stream_comparator #(
    parameter int WIDTH       = 8,
    parameter int SIGNED_MODE = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b,
    output logic [WIDTH-1:0] max_a,
    output logic [WIDTH-1:0] min_a,
    output logic [CNT_W-1:0] sample_cnt
);
    logic accept;
    logic empty;

    function automatic logic greater(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return (SIGNED_MODE != 0) ? ($signed(x) > $signed(y)) : (x > y);
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    // A clear in the same cycle as an accept restarts tracking from this sample
    assign empty    = clr || (sample_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            a_gt_b     <= 1'b0;
            a_eq_b     <= 1'b0;
            a_lt_b     <= 1'b0;
            max_a      <= '0;
            min_a      <= '0;
            sample_cnt <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            a_gt_b     <= greater(a, b);
            a_lt_b     <= greater(b, a);
            a_eq_b     <= (a == b);
            max_a      <= (empty || greater(a, max_a)) ? a : max_a;
            min_a      <= (empty || greater(min_a, a)) ? a : min_a;
            sample_cnt <= empty ? CNT_W'(1) : sample_cnt + CNT_W'(sample_cnt != '1);
        end else begin
            if (out_ready) out_valid <= 1'b0;
            if (clr) begin
                max_a      <= '0;
                min_a      <= '0;
                sample_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_stream_comparator.sv
// tb_stream_comparator: three WIDTH=4 instances (signed, unsigned, CNT_W=2) on shared stimulus,
// checked against a history-based model plus hand-computed expectations.
module tb_stream_comparator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, clr = 1'b0, out_ready = 1'b0;
    logic [3:0] a = '0, b = '0;
    logic s_ir, s_ov, s_gt, s_eq, s_lt;
    logic u_ir, u_ov, u_gt, u_eq, u_lt;
    logic t_ir, t_ov, t_gt, t_eq, t_lt;
    logic [3:0] s_mx, s_mn, u_mx, u_mn, t_mx, t_mn;
    logic [15:0] s_cnt, u_cnt;
    logic [1:0] t_cnt;
    int checks = 0, errors = 0;

    logic m_valid = 1'b0;
    logic [3:0] la = '0, lb = '0;
    logic [3:0] hist[$];

    always #5 clk = ~clk;

    stream_comparator #(.WIDTH(4), .SIGNED_MODE(1), .CNT_W(16)) u_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_ir), .a(a), .b(b), .clr(clr),
        .out_valid(s_ov), .out_ready(out_ready), .a_gt_b(s_gt), .a_eq_b(s_eq), .a_lt_b(s_lt),
        .max_a(s_mx), .min_a(s_mn), .sample_cnt(s_cnt));
    stream_comparator #(.WIDTH(4), .SIGNED_MODE(0), .CNT_W(16)) u_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_ir), .a(a), .b(b), .clr(clr),
        .out_valid(u_ov), .out_ready(out_ready), .a_gt_b(u_gt), .a_eq_b(u_eq), .a_lt_b(u_lt),
        .max_a(u_mx), .min_a(u_mn), .sample_cnt(u_cnt));
    stream_comparator #(.WIDTH(4), .SIGNED_MODE(1), .CNT_W(2)) u_t (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(t_ir), .a(a), .b(b), .clr(clr),
        .out_valid(t_ov), .out_ready(out_ready), .a_gt_b(t_gt), .a_eq_b(t_eq), .a_lt_b(t_lt),
        .max_a(t_mx), .min_a(t_mn), .sample_cnt(t_cnt));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int val(input logic [3:0] x, input bit sgn);
        return (sgn && x[3]) ? int'(x) - 16 : int'(x);
    endfunction

    function automatic logic [3:0] extreme(input bit sgn, input bit want_max);
        logic [3:0] best;
        if (hist.size() == 0) return 4'h0;
        best = hist[0];
        foreach (hist[i])
            if (want_max ? val(hist[i], sgn) > val(best, sgn) : val(hist[i], sgn) < val(best, sgn))
                best = hist[i];
        return best;
    endfunction

    task automatic chk_inst(input string n, input bit sgn, input int sat, input logic ir,
                            input logic ov, input logic gt, input logic eq, input logic lt,
                            input logic [3:0] mx, input logic [3:0] mn, input int cnt);
        chk({n, ".in_ready"}, ir, !m_valid || out_ready);
        chk({n, ".out_valid"}, ov, m_valid);
        if (m_valid) begin
            chk({n, ".gt"}, gt, val(la, sgn) > val(lb, sgn));
            chk({n, ".eq"}, eq, la == lb);
            chk({n, ".lt"}, lt, val(la, sgn) < val(lb, sgn));
        end
        chk({n, ".max"}, mx, extreme(sgn, 1'b1));
        chk({n, ".min"}, mn, extreme(sgn, 1'b0));
        chk({n, ".cnt"}, cnt, hist.size() > sat ? sat : hist.size());
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk_inst("s", 1'b1, 65535, s_ir, s_ov, s_gt, s_eq, s_lt, s_mx, s_mn, int'(s_cnt));
            chk_inst("u", 1'b0, 65535, u_ir, u_ov, u_gt, u_eq, u_lt, u_mx, u_mn, int'(u_cnt));
            chk_inst("t", 1'b1, 3, t_ir, t_ov, t_gt, t_eq, t_lt, t_mx, t_mn, int'(t_cnt));
        end
    end

    // Drive one cycle of inputs, advance the model at the edge, return 1 time unit later
    task automatic cyc(input logic iv, input logic [3:0] av, input logic [3:0] bv,
                       input logic ordy, input logic c);
        in_valid = iv; a = av; b = bv; out_ready = ordy; clr = c;
        @(posedge clk);
        if (rst_n) begin
            if (iv && (!m_valid || ordy)) begin
                m_valid = 1'b1; la = av; lb = bv;
                if (c) hist.delete();
                hist.push_back(av);
            end else begin
                if (ordy) m_valid = 1'b0;
                if (c) hist.delete();
            end
        end
        #1;
    endtask

    task automatic chk_all_zero(input string n);
        chk({n, ".ov"}, {s_ov, u_ov, t_ov}, 0);
        chk({n, ".flags"}, {s_gt, s_eq, s_lt, u_gt, u_eq, u_lt, t_gt, t_eq, t_lt}, 0);
        chk({n, ".mxmn"}, {s_mx, s_mn, u_mx, u_mn, t_mx, t_mn}, 0);
        chk({n, ".cnt"}, {s_cnt, u_cnt, t_cnt}, 0);
        chk({n, ".ir"}, {s_ir, u_ir, t_ir}, 3'b111);
    endtask

    initial begin
        #2 chk_all_zero("reset");
        @(posedge clk);
        cyc(1, 4'hF, 4'h1, 1, 0);
        chk_all_zero("held_in_reset");
        #3 rst_n = 1'b1;
        cyc(1, 4'hF, 4'h1, 1, 0);
        chk("r35.ov", s_ov, 1); chk("r35.lt", s_lt, 1); chk("r35.max", s_mx, 4'hF);
        chk("r35.min", s_mn, 4'hF); chk("r35.cnt", s_cnt, 1); chk("r36.gt", u_gt, 1);
        cyc(1, 4'h7, 4'h0, 1, 0);
        chk("r36.max", u_mx, 4'hF); chk("r36.min", u_mn, 4'h7); chk("r36.cnt", u_cnt, 2);
        chk("s.max7", s_mx, 4'h7); chk("s.minF", s_mn, 4'hF);
        repeat (3) begin
            cyc(1, 4'h2, 4'h5, 0, 0);
            chk("bp.ir", s_ir, 0); chk("bp.gt", s_gt, 1); chk("bp.cnt", s_cnt, 2);
        end
        cyc(1, 4'h2, 4'h5, 1, 0);
        chk("bp.ov", s_ov, 1); chk("bp.lt", s_lt, 1); chk("bp.cnt3", s_cnt, 3);
        cyc(0, 4'h0, 4'h0, 0, 1);
        chk("clr.cnt", s_cnt, 0); chk("clr.mx", {s_mx, s_mn}, 0); chk("clr.ov", s_ov, 1);
        chk("clr.lt", s_lt, 1);
        cyc(1, 4'h3, 4'h3, 1, 1);
        chk("clracc.mx", {s_mx, s_mn}, 8'h33); chk("clracc.cnt", s_cnt, 1); chk("clracc.eq", s_eq, 1);
        cyc(0, 4'h0, 4'h0, 1, 0);
        chk("drain.ov", s_ov, 0);
        cyc(0, 4'h0, 4'h0, 1, 1);
        cyc(1, 4'h8, 4'h0, 1, 0); chk("st.lt0", s_lt, 1);
        cyc(1, 4'h7, 4'h0, 1, 0); chk("st.gt1", s_gt, 1);
        cyc(1, 4'h0, 4'h0, 1, 0); chk("st.eq2", s_eq, 1);
        cyc(1, 4'h8, 4'h0, 1, 0); chk("st.lt3", s_lt, 1);
        chk("st.max", s_mx, 4'h7); chk("st.min", s_mn, 4'h8); chk("st.cnt", s_cnt, 4);
        chk("st.umax", u_mx, 4'h8); chk("st.umin", u_mn, 4'h0);
        cyc(1, 4'h1, 4'h0, 1, 0);
        chk("sat.cnt", t_cnt, 3); chk("sat.cnt5", s_cnt, 5);
        for (int i = 0; i < 60; i++)
            cyc(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
        cyc(1, 4'h5, 4'h2, 0, 0);
        chk("prerst.ov", s_ov, 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        m_valid = 1'b0; hist.delete();
        cyc(1, 4'h1, 4'h1, 1, 0);
        chk_all_zero("rst_no_accept");
        rst_n = 1'b1;
        cyc(1, 4'h4, 4'h4, 1, 0);
        chk("post.ov", s_ov, 1); chk("post.eq", s_eq, 1); chk("post.cnt", t_cnt, 1);
        cyc(0, 4'h0, 4'h0, 1, 0);
        @(negedge clk);
        #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
